// File: rtl/aes128_stream_feeder_pkg.sv
// aes_pkg: block/byte widths and feeder state encoding shared by the feeder files
package aes_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTE_W = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int CNT_W = $clog2(BLOCK_BYTES);
  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    WAIT_KEY  = 3'd1,
    LOAD      = 3'd2,
    WAIT_CLR  = 3'd3,
    WAIT_DONE = 3'd4,
    DRAIN     = 3'd5,
    ERROR     = 3'd6
  } state_e;
endpackage

// File: rtl/aes128_stream_feeder_if.sv
// aes128_stream_feeder_if: byte-stream input/output handshakes plus the per-block mode select
interface aes128_stream_feeder_if;
  import aes_pkg::*;
  logic mode_i;
  logic [BYTE_W-1:0] s_data_i;
  logic s_valid_i;
  logic s_ready_o;
  logic [BYTE_W-1:0] m_data_o;
  logic m_valid_o;
  logic m_ready_i;
  modport slave (input mode_i, s_data_i, s_valid_i, m_ready_i, output s_ready_o, m_data_o, m_valid_o);
  modport master (output mode_i, s_data_i, s_valid_i, m_ready_i, input s_ready_o, m_data_o, m_valid_o);
endinterface

// File: rtl/aes128_stream_feeder_packer.sv
// aes_byte_packer: byte shift register with beat counter, shared by block assembly and drain
module aes_byte_packer
  import aes_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               shift_i,
  input  logic               load_i,
  input  logic [BYTE_W-1:0]  byte_i,
  input  logic [BLOCK_W-1:0] block_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic [BYTE_W-1:0]  byte_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               last_o
);
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    block_d = load_i ? block_i : shift_i ? {block_q[BLOCK_W-BYTE_W-1:0], byte_i} : block_q;
    cnt_d = load_i ? '0 : shift_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      block_q <= '0;
      cnt_q <= '0;
    end else begin
      block_q <= block_d;
      cnt_q <= cnt_d;
    end
  end
  assign block_o = block_q;
  assign byte_o = block_q[BLOCK_W-1 -: BYTE_W];
  assign cnt_o = cnt_q;
  assign last_o = cnt_q == CNT_W'(BLOCK_BYTES - 1);
endmodule

// File: rtl/aes128_stream_feeder.sv
// aes128_stream_feeder: byte-stream front/back end for the iterative AES-128 core
// Define AES_FEEDER_CBC_EN to add the CBC chain register loaded from iv_i/iv_load_i.
module aes128_stream_feeder
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  aes128_stream_feeder_if.slave st,
  input  logic               key_ready_i,
  output logic               load_data_o,
  output logic [BLOCK_W-1:0] plain_text_o,
  output logic               enc_or_dec_o,
  input  logic [BLOCK_W-1:0] cipher_text_i,
  input  logic               cipher_ready_i,
  input  logic [BLOCK_W-1:0] iv_i,
  input  logic               iv_load_i,
  output logic               busy_o,
  output logic               error_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic enc_q, enc_d;
  logic s_acc, m_acc, capture, last;
  logic [BLOCK_W-1:0] block, result;
  logic [BYTE_W-1:0] byte_out;
  logic [CNT_W-1:0] cnt;
  // losing key_ready while the core is busy means a rekey corrupted this block
  always_comb begin
    s_acc = state_q == COLLECT && st.s_valid_i;
    m_acc = state_q == DRAIN && st.m_ready_i;
    capture = state_q == WAIT_DONE && key_ready_i && cipher_ready_i;
    state_d = state_q;
    case (state_q)
      COLLECT:   state_d = s_acc && last ? WAIT_KEY : COLLECT;
      WAIT_KEY:  state_d = key_ready_i ? LOAD : WAIT_KEY;
      LOAD:      state_d = WAIT_CLR;
      WAIT_CLR:  state_d = key_ready_i ? WAIT_DONE : ERROR;
      WAIT_DONE: state_d = !key_ready_i ? ERROR : cipher_ready_i ? DRAIN :
                           tmo_q == TW'(TIMEOUT_CYCLES - 1) ? ERROR : WAIT_DONE;
      DRAIN:     state_d = m_acc && last ? COLLECT : DRAIN;
      default:   state_d = ERROR;
    endcase
    tmo_d = state_q == WAIT_DONE ? tmo_q + 1'b1 : '0;
    enc_d = s_acc && cnt == '0 ? st.mode_i : enc_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= COLLECT;
      tmo_q <= '0;
      enc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      enc_q <= enc_d;
    end
  end
`ifdef AES_FEEDER_CBC_EN
  logic [BLOCK_W-1:0] chain_q, chain_d;
  always_comb begin
    chain_d = state_q == COLLECT && cnt == '0 && iv_load_i ? iv_i :
              capture ? (enc_q ? cipher_text_i : block) : chain_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) chain_q <= '0;
    else chain_q <= chain_d;
  end
  assign plain_text_o = enc_q ? block ^ chain_q : block;
  assign result = enc_q ? cipher_text_i : cipher_text_i ^ chain_q;
`else
  logic unused_iv;
  assign unused_iv = ^{iv_i, iv_load_i};
  assign plain_text_o = block;
  assign result = cipher_text_i;
`endif
  aes_byte_packer u_packer (
    .clk_i,
    .reset_i,
    .shift_i (s_acc || m_acc),
    .load_i  (capture),
    .byte_i  (st.s_data_i),
    .block_i (result),
    .block_o (block),
    .byte_o  (byte_out),
    .cnt_o   (cnt),
    .last_o  (last)
  );
  assign st.s_ready_o = state_q == COLLECT;
  assign st.m_valid_o = state_q == DRAIN;
  assign st.m_data_o = byte_out;
  assign load_data_o = state_q == LOAD;
  assign enc_or_dec_o = enc_q;
  assign busy_o = state_q != COLLECT;
  assign error_o = state_q == ERROR;
endmodule

// File: tb/tb_aes128_stream_feeder.sv
// tb_aes128_stream_feeder: randomized stream scoreboard around a behavioural AES core model
module tb_aes128_stream_feeder;
  localparam int T = 32;
  localparam int LAT = 11;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic key_ready_i = 1'b1;
  logic cipher_ready_i = 1'b0;
  logic iv_load_i = 1'b0;
  logic [127:0] cipher_text_i = '0;
  logic [127:0] iv_i = '0;
  logic [127:0] plain_text_o;
  logic load_data_o, enc_or_dec_o, busy_o, error_o;

  aes128_stream_feeder_if ifc ();
  aes128_stream_feeder #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .reset_i(reset_i), .st(ifc), .key_ready_i(key_ready_i),
    .load_data_o(load_data_o), .plain_text_o(plain_text_o), .enc_or_dec_o(enc_or_dec_o),
    .cipher_text_i(cipher_text_i), .cipher_ready_i(cipher_ready_i), .iv_i(iv_i),
    .iv_load_i(iv_load_i), .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int unsigned rdy_pct = 100, gap = 0;
  int n_acc = 0, n_load = 0;
  logic [7:0] exp_q[$];
  logic [127:0] chain = '0;
  bit core_dead = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // stand-in core: FIPS-197 vector pair, otherwise a mode-dependent scramble
  function automatic logic [127:0] core_f(input logic [127:0] b, input logic enc);
    if (enc) return b == FIPS_P ? FIPS_C : {b[100:0], b[127:101]} ^ 128'h0123456789abcdeffedcba9876543210;
    return b == FIPS_C ? FIPS_P : ~{b[63:0], b[127:64]};
  endfunction

  // stale ready stays high two negedges past the load, then the result arrives after LAT
  logic [127:0] cr_blk = '0;
  int cr_cnt = 0, stale = 0;
  always @(negedge clk) begin
    if (load_data_o) begin
      cr_blk <= core_f(plain_text_o, enc_or_dec_o);
      cr_cnt <= LAT;
      stale <= 2;
    end else begin
      if (stale == 1) cipher_ready_i <= 1'b0;
      if (stale > 0) stale <= stale - 1;
      if (cr_cnt > 0) cr_cnt <= cr_cnt - 1;
      if (cr_cnt == 1 && !core_dead) begin
        cipher_ready_i <= 1'b1;
        cipher_text_i <= cr_blk;
      end
    end
  end

  always @(negedge clk) begin
    ifc.m_ready_i = $urandom_range(0, 99) < rdy_pct;
    if (load_data_o) n_load++;
    if (!reset_i && ifc.m_valid_o) begin
      check("s_ready_in_drain", 128'(ifc.s_ready_o), 0);
      if (ifc.m_ready_i) begin
        n_acc++;
        check("out_pending", 128'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("out_byte", 128'(ifc.m_data_o), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_exp(input logic [127:0] blk, input logic md);
    logic [127:0] o;
`ifdef AES_FEEDER_CBC_EN
    if (md) begin
      o = core_f(blk ^ chain, 1'b1);
      chain = o;
    end else begin
      o = core_f(blk, 1'b0) ^ chain;
      chain = blk;
    end
`else
    o = core_f(blk, md);
`endif
    for (int i = 15; i >= 0; i--) exp_q.push_back(o[8*i +: 8]);
  endtask

  task automatic send_block(input logic [127:0] blk, input logic md);
    int w;
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 99) < gap) begin
        ifc.s_valid_i = 1'b0;
        @(negedge clk);
      end
      ifc.s_valid_i = 1'b1;
      ifc.s_data_i = blk[127-8*i -: 8];
      ifc.mode_i = i == 0 ? md : 1'($urandom);
      w = 0;
      while (!ifc.s_ready_o && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) begin
        check("s_ready_wait", 128'(ifc.s_ready_o), 1);
        ifc.s_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ifc.s_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("drain_done", 128'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    check("idle_busy", 128'(busy_o), 0);
    check("idle_s_ready", 128'(ifc.s_ready_o), 1);
  endtask

  task automatic run_block(input logic [127:0] blk, input logic md);
    int l0;
    l0 = n_load;
    push_exp(blk, md);
    send_block(blk, md);
    wait_drain();
    check("load_pulses", 128'(n_load - l0), 1);
    check("no_error", 128'(error_o), 0);
    check("mode_latched", 128'(enc_or_dec_o), 128'(md));
  endtask

  task automatic wait_load();
    int c;
    c = 0;
    while (!load_data_o && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("load_seen", 128'(load_data_o), 1);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    ifc.s_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    exp_q.delete();
    chain = '0;
    check("reset_error", 128'(error_o), 0);
    check("reset_busy", 128'(busy_o), 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int l0, a0, c;
    ifc.s_valid_i = 1'b0;
    ifc.s_data_i = '0;
    ifc.mode_i = 1'b0;
    ifc.m_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 128'(ifc.s_ready_o), 1);
    check("rst_m_valid", 128'(ifc.m_valid_o), 0);
    check("rst_load", 128'(load_data_o), 0);
    check("rst_busy", 128'(busy_o), 0);
    check("rst_error", 128'(error_o), 0);
    check("rst_plain", plain_text_o, 0);
    check("rst_mode", 128'(enc_or_dec_o), 0);
    reset_i = 1'b0;

    run_block(FIPS_P, 1'b1);
    run_block(FIPS_C, 1'b0);

    rdy_pct = 50;
    gap = 50;
    for (int i = 0; i < 4; i++) run_block(rnd128(), 1'($urandom));

    gap = 0;
    begin
      logic [127:0] b1, b2;
      b1 = rnd128();
      b2 = rnd128();
      l0 = n_load;
      push_exp(b1, 1'b1);
      push_exp(b2, 1'b0);
      send_block(b1, 1'b1);
      send_block(b2, 1'b0);
      wait_drain();
      check("b2b_loads", 128'(n_load - l0), 2);
    end

    rdy_pct = 100;
    key_ready_i = 1'b0;
    begin
      logic [127:0] b;
      b = rnd128();
      l0 = n_load;
      push_exp(b, 1'b1);
      send_block(b, 1'b1);
      repeat (6) @(negedge clk);
      check("keywait_no_load", 128'(n_load - l0), 0);
      check("keywait_busy", 128'(busy_o), 1);
      check("keywait_s_ready", 128'(ifc.s_ready_o), 0);
      key_ready_i = 1'b1;
      wait_drain();
      check("keywait_loads", 128'(n_load - l0), 1);
    end

    begin
      logic [127:0] b;
      b = rnd128();
      push_exp(b, 1'b0);
      a0 = n_acc;
      send_block(b, 1'b0);
      c = 0;
      while (n_acc - a0 < 5 && c < 500) begin
        @(negedge clk);
        c++;
      end
      check("drain5_reached", 128'(n_acc - a0 >= 5), 1);
      reset_i = 1'b1;
      @(negedge clk);
      check("rst_drain_m_valid", 128'(ifc.m_valid_o), 0);
      check("rst_drain_s_ready", 128'(ifc.s_ready_o), 1);
      reset_i = 1'b0;
      exp_q.delete();
      chain = '0;
      run_block(rnd128(), 1'b1);
    end

    send_block(rnd128(), 1'b1);
    wait_load();
    key_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rekey_error", 128'(error_o), 1);
    check("err_busy", 128'(busy_o), 1);
    check("err_s_ready", 128'(ifc.s_ready_o), 0);
    check("err_m_valid", 128'(ifc.m_valid_o), 0);
    key_ready_i = 1'b1;
    do_reset();

    core_dead = 1;
    send_block(rnd128(), 1'b0);
    wait_load();
    for (int n = 1; n <= T + 4; n++) begin
      @(negedge clk);
      check("timeout", 128'(error_o), 128'(n >= T + 2));
    end
    repeat (5) @(negedge clk);
    check("timeout_sticky", 128'(error_o), 1);
    check("timeout_m_valid", 128'(ifc.m_valid_o), 0);
    core_dead = 0;
    do_reset();
    run_block(rnd128(), 1'b0);

`ifdef AES_FEEDER_CBC_EN
    iv_i = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load_i = 1'b1;
    @(negedge clk);
    iv_load_i = 1'b0;
    chain = iv_i;
    run_block(rnd128(), 1'b1);
    run_block(rnd128(), 1'b1);
    run_block(rnd128(), 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes128_stream_feeder.md
Name: aes128_stream_feeder

Overview:
- Byte-stream front/back end for the AES-128 iterative core.
- Collects 16 input bytes into a 128-bit block and waits for the core's key-ready.
- Pulses the core's load strobe, waits for the core's ready flag, captures the result, then streams the 16 result bytes out.
- Holds the encrypt/decrypt select stable for the whole block, because the core samples it every cycle.

Parameters:
- TIMEOUT_CYCLES, 32: maximum cycles spent waiting for the core's ready flag after a load before the block is abandoned with an error.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- mode_i  in  1  1 = encrypt, 0 = decrypt; latched when byte 0 of a block is accepted.
- s_data_i  in  8  input byte.
- s_valid_i  in  1  input byte valid.
- s_ready_o  out  1  feeder can accept an input byte.
- m_data_o  out  8  output byte.
- m_valid_o  out  1  output byte valid.
- m_ready_i  in  1  downstream accepts the output byte.
- key_ready_i  in  1  core round keys valid.
- load_data_o  out  1  one-cycle load strobe to the core.
- plain_text_o  out  128  block presented to the core.
- enc_or_dec_o  out  1  mode to the core.
- cipher_text_i  in  128  core result.
- cipher_ready_i  in  1  core result valid.
- iv_i  in  128  chaining IV; used only with the optional feature.
- iv_load_i  in  1  load iv_i into the chain register; used only with the optional feature.
- busy_o  out  1  high in any state other than COLLECT.
- error_o  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset values:
  - State COLLECT, byte count 0.
  - s_ready_o=1; m_valid_o=0; load_data_o=0; busy_o=0; error_o=0.
  - plain_text_o, enc_or_dec_o and the chain register are 0.
- Reset mid-operation discards any partial or in-flight block.
- Byte order: the first byte transferred maps to bits [127:120]; output uses the same order.
- COLLECT:
  - s_ready_o=1; a byte is accepted when s_valid_i & s_ready_o.
  - Accepting byte 0 latches mode_i into enc_or_dec_o.
  - Accepting byte 15 registers the block and moves to WAIT_KEY on the next cycle.
- WAIT_KEY: s_ready_o=0; when key_ready_i=1, move to LOAD.
- LOAD: load_data_o=1 for exactly one cycle, then WAIT_CLR.
- WAIT_CLR: one cycle in which cipher_ready_i is ignored, because the core's flag is stale from the previous block. Then WAIT_DONE.
- WAIT_DONE:
  - The timeout counter starts at 0 and increments each cycle.
  - If cipher_ready_i=1: capture cipher_text_i and go to DRAIN.
  - Else if the counter reaches TIMEOUT_CYCLES-1: go to ERROR.
- key_ready_i=0 in WAIT_CLR or WAIT_DONE (rekey mid-block) also goes to ERROR.
- DRAIN:
  - m_valid_o=1 and m_data_o = the current byte.
  - The byte index advances only on m_valid_o & m_ready_i.
  - After byte 15 is accepted, return to COLLECT with byte count 0.
  - s_ready_o=0 throughout; there is no overlap of input and output.
- ERROR:
  - error_o=1 and busy_o=1.
  - s_ready_o=0 and m_valid_o=0.
  - Stays in ERROR until reset.
- Latency: with the core's 11-cycle encrypt or decrypt, the first output byte appears 1 (WAIT_KEY) + 1 (LOAD) + 1 (WAIT_CLR) + 11 = about 14 cycles after byte 15 is accepted, with key_ready_i already high.
- Throughput: one block per 16 input beats + ~14 + 16 output beats.
- enc_or_dec_o changes only in COLLECT, on acceptance of byte 0.

Optional Feature:
- Macro: AES_FEEDER_CBC_EN.
- Defined:
  - iv_load_i in COLLECT with byte count 0 loads the chain register from iv_i.
  - Encrypt: plain_text_o = assembled block ^ chain; chain <= cipher_text_i on capture.
  - Decrypt: output block = cipher_text_i ^ chain; chain <= the assembled input block.
  - iv_load_i in other states is ignored.
- Undefined: iv_i and iv_load_i are ignored; ECB behaviour; no chain register is synthesized.

Decomposition:
- Shared package aes_pkg holds:
  - block/byte width constants: BLOCK_W=128, BYTE_W=8, BLOCK_BYTES=16.
  - state encoding localparams: COLLECT, WAIT_KEY, LOAD, WAIT_CLR, WAIT_DONE, DRAIN, ERROR.
- One natural sub-module: aes_byte_packer, a shift register with byte counter used for both assembly and drain.

Test Plan:
- FIPS-197 encrypt, bench driving a real aes128 core:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, mode=1, stream 00112233445566778899aabbccddeeff.
  - Response: output stream 69c4e0d86a7b0430d8cdb78070b4c55a; one load_data_o pulse; error_o=0.
- Decrypt: same key, mode=0, stream 69c4e0d8...c55a -> output 00112233...eeff.
- Backpressure: random m_ready_i (50%) and gappy s_valid_i -> byte order preserved; no duplicate or dropped bytes; s_ready_o=0 during DRAIN.
- Stale ready: two back-to-back blocks -> second block not captured from the leftover cipher_ready_i; both outputs correct.
- Timeout: cipher_ready_i tied 0 after load -> error_o=1 exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE; stays 1; reset clears it.
- Reset mid-DRAIN after 5 output bytes -> m_valid_o=0 next cycle; next full block processed correctly.
- With AES_FEEDER_CBC_EN: IV 000102...0f, two-block CBC encrypt of the NIST SP800-38A vectors -> matches the reference ciphertexts.
